// File: rtl/trainled2_encoder.sv
// TrainLED2 chain driver: takes pixel bytes over a valid/ready stream and emits
// pulse-width coded bits (MSB first) on dout, closing each frame with a low latch gap.
module trainled2_encoder #(
    parameter int TBIT = 64,
    parameter int T0H  = 16,
    parameter int T1H  = 48,
    parameter int TGAP = 1024,
    parameter int CW   = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_last,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       dout,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Terminal counts: the counter restarts at 0 on each state entry, so a
    // phase of N cycles ends on the edge where the counter reads N-1.
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] T0H_END  = CW'(T0H - 1);
    localparam logic [CW-1:0] T1H_END  = CW'(T1H - 1);
    localparam logic [CW-1:0] LOW0_END = CW'(TBIT - T0H - 1);
    localparam logic [CW-1:0] LOW1_END = CW'(TBIT - T1H - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(TGAP - 1);

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    shifter, shifter_next;
    logic          last_q, last_next;
    logic          dout_next, frame_done_next, underrun_next;

    logic [7:0]    hold_data;
    logic          hold_last;
    logic          hold_full;
    logic          accept;
    logic          load;

    // Stream handshake: a byte transfers on a clk edge where s_valid && s_ready.
    // s_ready depends only on the holding flag, never on s_valid.
    assign s_ready = !hold_full;
    assign accept  = s_valid && s_ready;
    assign busy    = (state != IDLE) || hold_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_data <= 8'h00;
            hold_last <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= s_data;
            hold_last <= s_last;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= 3'd0;
            shifter    <= 8'h00;
            last_q     <= 1'b0;
            dout       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            bit_cnt    <= bit_cnt_next;
            shifter    <= shifter_next;
            last_q     <= last_next;
            dout       <= dout_next;
            frame_done <= frame_done_next;
            underrun   <= underrun_next;
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt + ONE;
        bit_cnt_next    = bit_cnt;
        shifter_next    = shifter;
        last_next       = last_q;
        dout_next       = 1'b0;
        frame_done_next = 1'b0;
        underrun_next   = 1'b0;
        load            = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (hold_full) begin
                    load       = 1'b1;
                    state_next = HIGH;
                    dout_next  = 1'b1;
                end
            end

            HIGH: begin
                dout_next = 1'b1;
                if (cnt == (shifter[7] ? T1H_END : T0H_END)) begin
                    state_next = LOW;
                    cnt_next   = '0;
                    dout_next  = 1'b0;
                end
            end

            LOW: begin
                if (cnt == (shifter[7] ? LOW1_END : LOW0_END)) begin
                    cnt_next = '0;
                    if (bit_cnt != 3'd0) begin
                        shifter_next = {shifter[6:0], 1'b0};
                        bit_cnt_next = bit_cnt - 3'd1;
                        state_next   = HIGH;
                        dout_next    = 1'b1;
                    end else if (last_q) begin
                        state_next = GAP;
                    end else if (hold_full) begin
                        // Back-to-back byte: next rise lands exactly one bit period on.
                        load       = 1'b1;
                        state_next = HIGH;
                        dout_next  = 1'b1;
                    end else begin
                        underrun_next = 1'b1;
                        state_next    = GAP;
                    end
                end
            end

            GAP: begin
                if (cnt == GAP_END) begin
                    state_next      = IDLE;
                    cnt_next        = '0;
                    frame_done_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        if (load) begin
            shifter_next = hold_data;
            bit_cnt_next = 3'd7;
            last_next    = hold_last;
        end
    end

endmodule

// File: tb/tb_trainled2_encoder.sv
// Bench for trainled2_encoder: a pulse-level model of the line (expected bit
// queue, period/width/gap timing) plus directed frames with literal expectations.
module tb_trainled2_encoder;

    localparam int TBIT = 64;
    localparam int T0H  = 16;
    localparam int T1H  = 48;
    localparam int TGAP = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready, dout, busy, frame_done, underrun;

    logic [7:0] s_data2 = 8'h00;
    logic       s_last2 = 1'b0;
    logic       s_valid2 = 1'b0;
    logic       s_ready2, dout2, busy2, frame_done2, underrun2;

    trainled2_encoder dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .dout(dout), .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );

    trainled2_encoder #(.TBIT(8), .T0H(2), .T1H(5), .TGAP(20), .CW(5)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data2), .s_last(s_last2), .s_valid(s_valid2), .s_ready(s_ready2),
        .dout(dout2), .busy(busy2), .frame_done(frame_done2), .underrun(underrun2)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic exp_q[$];
    int   wq[$];
    bit   in_frame = 1'b0;
    logic cur_bit = 1'b0;
    logic prev_dout = 1'b0, prev_fd = 1'b0, prev_ur = 1'b0;
    int   first_rise = 0, last_rise = 0, frame_rises = 0, total_rises = 0;
    int   last_frame_rises = 0;
    int   fd_count = 0, ur_count = 0, fd_cyc = 0, ur_cyc = 0;
    int   last_acc = 0;

    // Line monitor: every rise consumes one expected bit, every fall checks
    // the high time, and frame_done/underrun are timed from the last rise.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_dout = 1'b0;
            prev_fd   = 1'b0;
            prev_ur   = 1'b0;
            in_frame  = 1'b0;
        end else begin
            if (dout && !prev_dout) begin
                if (!in_frame) begin
                    in_frame    = 1'b1;
                    frame_rises = 0;
                    wq.delete();
                    first_rise  = cyc;
                end else begin
                    check("rise_spacing", cyc - last_rise, TBIT);
                end
                frame_rises++;
                total_rises++;
                last_rise = cyc;
                check("rise_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) cur_bit = exp_q.pop_front();
            end
            if (!dout && prev_dout) begin
                wq.push_back(cyc - last_rise);
                check("high_time", cyc - last_rise, cur_bit ? T1H : T0H);
            end
            if (frame_done) begin
                check("frame_done_in_frame", in_frame, 1);
                check("frame_done_time", cyc - last_rise, TBIT + TGAP);
                check("frame_done_width", prev_fd, 0);
                in_frame         = 1'b0;
                last_frame_rises = frame_rises;
                fd_count++;
                fd_cyc = cyc;
            end
            if (underrun) begin
                check("underrun_time", cyc - last_rise, TBIT);
                check("underrun_width", prev_ur, 0);
                ur_count++;
                ur_cyc = cyc;
            end
            prev_dout = dout;
            prev_fd   = frame_done;
            prev_ur   = underrun;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_seen", s_ready, 1);
        if (s_ready) begin
            @(posedge clk);
            #1;
            last_acc = cyc;
            for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
            check("ready_low_after_accept", s_ready, 0);
            check("busy_after_accept", busy, 1);
        end
    endtask

    task automatic drop_valid();
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_fd(input int budget);
        int start = fd_count;
        int n = 0;
        while (fd_count == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("frame_done_seen", fd_count != start, 1);
    endtask

    task automatic wait_ur(input int budget);
        int start = ur_count;
        int n = 0;
        while (ur_count == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("underrun_seen", ur_count != start, 1);
    endtask

    task automatic wait_rises(input int k, input int budget);
        int n = 0;
        while (!(in_frame && frame_rises >= k) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("rises_reached", in_frame && frame_rises >= k, 1);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_dout_idle"}, dout, 0);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_ready_idle"}, s_ready, 1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int acc, r, prev_fd_cyc, exp_fd;
        int exp_a[8];
        int exp_f[8];
        int w2[$];
        int r2, rise2, fd2;
        logic p2;
        exp_a  = '{48, 16, 48, 16, 16, 48, 16, 48};
        exp_f  = '{2, 2, 5, 5, 5, 5, 2, 2};
        exp_fd = 0;

        // Reset values
        #1;
        check("rst_dout", dout, 0);
        check("rst_ready", s_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_underrun", underrun, 0);
        check("rst_small_dout", dout2, 0);
        check("rst_small_ready", s_ready2, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // A: single byte 0xA5, last
        send_byte(8'hA5, 1'b1);
        acc = last_acc;
        drop_valid();
        wait_fd(3000);
        exp_fd++;
        check("a_accept_to_rise", first_rise - acc, 1);
        check("a_frame_len", fd_cyc - first_rise, 8 * 64 + 1024);
        check("a_rises", last_frame_rises, 8);
        check("a_widths_count", wq.size(), 8);
        for (int i = 0; i < 8; i++)
            check("a_width", (i < wq.size()) ? wq[i] : -1, exp_a[i]);
        check_idle("a");

        // B: 3-byte frame 0xFF,0x00,0x81 with valid held high
        send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h81, 1'b1);
        drop_valid();
        wait_fd(4000);
        exp_fd++;
        check("b_rises", last_frame_rises, 24);
        check("b_frame_len", fd_cyc - first_rise, 24 * 64 + 1024);
        check("b_w0", (wq.size() == 24) ? wq[0] : -1, 48);
        check("b_w8", (wq.size() == 24) ? wq[8] : -1, 16);
        check("b_w16", (wq.size() == 24) ? wq[16] : -1, 48);
        check("b_w17", (wq.size() == 24) ? wq[17] : -1, 16);
        check("b_w23", (wq.size() == 24) ? wq[23] : -1, 48);
        check_idle("b");

        // C: 0x80 without last and no follow-up -> underrun, then gap
        send_byte(8'h80, 1'b0);
        drop_valid();
        wait_ur(1000);
        check("c_underrun_at", ur_cyc - first_rise, 512);
        wait_fd(2000);
        exp_fd++;
        check("c_frame_len", fd_cyc - first_rise, 512 + 1024);
        check("c_rises", last_frame_rises, 8);
        check("c_w0", (wq.size() == 8) ? wq[0] : -1, 48);
        check("c_w1", (wq.size() == 8) ? wq[1] : -1, 16);
        r = total_rises;
        repeat (200) @(posedge clk);
        check("c_quiet_after", total_rises - r, 0);
        check_idle("c");

        // D: byte offered during an active gap waits for IDLE
        send_byte(8'h55, 1'b1);
        drop_valid();
        wait_rises(8, 1000);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("d_in_gap_dout", dout, 0);
        send_byte(8'h01, 1'b1);
        drop_valid();
        r = total_rises;
        wait_fd(2000);
        exp_fd++;
        check("d_no_rise_in_gap", total_rises - r, 0);
        check("d_first_frame_len", fd_cyc - first_rise, 8 * 64 + 1024);
        prev_fd_cyc = fd_cyc;
        wait_fd(3000);
        exp_fd++;
        check("d_idle_to_rise", first_rise - prev_fd_cyc, 1);
        check("d_w6", (wq.size() == 8) ? wq[6] : -1, 16);
        check("d_w7", (wq.size() == 8) ? wq[7] : -1, 48);
        check_idle("d");

        // E: reset pulse while dout is high in bit 4, then a clean frame
        send_byte(8'hFF, 1'b1);
        drop_valid();
        wait_rises(4, 1000);
        @(negedge clk);
        check("e_high_before_reset", dout, 1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("e_async_dout", dout, 0);
        check("e_async_ready", s_ready, 1);
        check("e_async_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'hA5, 1'b1);
        acc = last_acc;
        drop_valid();
        wait_fd(3000);
        exp_fd++;
        check("e_accept_to_rise", first_rise - acc, 1);
        check("e_rises", last_frame_rises, 8);
        check("e_frame_len", fd_cyc - first_rise, 8 * 64 + 1024);
        check("e_w0", (wq.size() == 8) ? wq[0] : -1, 48);
        check("e_w1", (wq.size() == 8) ? wq[1] : -1, 16);

        // F: small-parameter instance, byte 0x3C last
        @(negedge clk);
        s_valid2 = 1'b1;
        s_data2  = 8'h3C;
        s_last2  = 1'b1;
        check("f_ready", s_ready2, 1);
        @(posedge clk);
        #1;
        acc = cyc;
        @(negedge clk);
        s_valid2 = 1'b0;
        p2 = 1'b0; r2 = -1; rise2 = 0; fd2 = -1;
        for (int t = 0; t < 150 && fd2 < 0; t++) begin
            if (dout2 && !p2) begin
                if (r2 < 0) r2 = cyc;
                rise2 = cyc;
            end
            if (!dout2 && p2) w2.push_back(cyc - rise2);
            if (frame_done2) fd2 = cyc;
            p2 = dout2;
            @(negedge clk);
        end
        check("f_frame_done_seen", fd2 >= 0, 1);
        check("f_accept_to_rise", r2 - acc, 1);
        check("f_frame_len", fd2 - r2, 8 * 8 + 20);
        check("f_widths_count", w2.size(), 8);
        for (int i = 0; i < 8; i++)
            check("f_width", (i < w2.size()) ? w2[i] : -1, exp_f[i]);
        check("f_underrun", underrun2, 0);
        check("f_busy_end", busy2, 0);

        // Final bookkeeping
        repeat (5) @(posedge clk);
        check("end_exp_queue_empty", exp_q.size(), 0);
        check("end_frame_done_count", fd_count, exp_fd);
        check("end_underrun_count", ur_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
